// File: rtl/ks_note_seq.sv
// Karplus-Strong note sequencer: plays a programmable table of {period, duration} notes.
// Optional loop playback is enabled by defining KS_SEQ_LOOP_EN.
module ks_note_seq #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_i,
  input  logic                         wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_period_i,
  input  logic [DATA_WIDTH-1:0]        wr_dur_i,
  input  logic [$clog2(DEPTH):0]       len_i,
  input  logic [DATA_WIDTH-1:0]        tempo_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         loop_i,
  output logic                         pluck_o,
  output logic [DATA_WIDTH-1:0]        period_o,
  output logic [$clog2(DEPTH)-1:0]     idx_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   period_tab_q [DEPTH];
  logic [DW-1:0]   dur_tab_q    [DEPTH];
  logic [AW-1:0]   idx_q, idx_d, last_q, last_d;
  logic [DW-1:0]   tempo_q, tempo_d, period_q, period_d;
  logic [DW-1:0]   dur_cnt_q, dur_cnt_d, unit_cnt_q, unit_cnt_d;
  logic [1:0]      pluck_cnt_q, pluck_cnt_d;
  logic            pluck_q, pluck_d, busy_q, busy_d, done_q, done_d;
  logic [AW:0]     len_clamp_c;
  logic [DW-1:0]   tab_dur_c;

`ifdef KS_SEQ_LOOP_EN
  logic            loop_q, loop_d;
`else
  logic            unused_loop;
  assign unused_loop = loop_i;
`endif

  // Clamp requested length into 1..DEPTH
  always_comb begin
    len_clamp_c = len_i;
    if (len_i == '0)
      len_clamp_c = (AW+1)'(1);
    else if (len_i > (AW+1)'(DEPTH))
      len_clamp_c = (AW+1)'(DEPTH);
  end

  assign tab_dur_c = dur_tab_q[idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    tempo_d     = tempo_q;
    period_d    = period_q;
    dur_cnt_d   = dur_cnt_q;
    unit_cnt_d  = unit_cnt_q;
    pluck_cnt_d = pluck_cnt_q;
    pluck_d     = pluck_q;
    done_d      = 1'b0;
`ifdef KS_SEQ_LOOP_EN
    loop_d      = loop_q;
`endif
    if (stop_i) begin
      state_d = S_IDLE;
      pluck_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            idx_d   = '0;
            last_d  = AW'(len_clamp_c - (AW+1)'(1));
            tempo_d = (tempo_i == '0) ? DW'(1) : tempo_i;
`ifdef KS_SEQ_LOOP_EN
            loop_d  = loop_i;
`endif
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          period_d    = period_tab_q[idx_q];
          dur_cnt_d   = (tab_dur_c == '0) ? DW'(1) : tab_dur_c;
          unit_cnt_d  = tempo_q;
          pluck_cnt_d = 2'd0;
          pluck_d     = 1'b1;
          state_d     = S_PLAY;
        end
        S_PLAY: begin
          if (tick_i) begin
            // Pluck drops on the second tick of the note
            if (pluck_cnt_q != 2'd2) pluck_cnt_d = pluck_cnt_q + 2'd1;
            if (pluck_cnt_q != 2'd0) pluck_d = 1'b0;
            if (unit_cnt_q <= DW'(1)) begin
              unit_cnt_d = tempo_q;
              if (dur_cnt_q <= DW'(1)) begin
                dur_cnt_d = '0;
                pluck_d   = 1'b0;
                if (idx_q != last_q) begin
                  idx_d   = idx_q + AW'(1);
                  state_d = S_LOAD;
                end else begin
`ifdef KS_SEQ_LOOP_EN
                  if (loop_q) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                  end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                  end
`else
                  state_d = S_IDLE;
                  done_d  = 1'b1;
`endif
                end
              end else begin
                dur_cnt_d = dur_cnt_q - DW'(1);
              end
            end else begin
              unit_cnt_d = unit_cnt_q - DW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      tempo_q     <= '0;
      period_q    <= '0;
      dur_cnt_q   <= '0;
      unit_cnt_q  <= '0;
      pluck_cnt_q <= '0;
      pluck_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef KS_SEQ_LOOP_EN
      loop_q      <= 1'b0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) begin
        period_tab_q[i] <= '0;
        dur_tab_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      tempo_q     <= tempo_d;
      period_q    <= period_d;
      dur_cnt_q   <= dur_cnt_d;
      unit_cnt_q  <= unit_cnt_d;
      pluck_cnt_q <= pluck_cnt_d;
      pluck_q     <= pluck_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef KS_SEQ_LOOP_EN
      loop_q      <= loop_d;
`endif
      // A LOAD in this same cycle still reads the previous entry value
      if (wr_en_i) begin
        period_tab_q[wr_addr_i] <= wr_period_i;
        dur_tab_q[wr_addr_i]    <= wr_dur_i;
      end
    end
  end

  assign pluck_o  = pluck_q;
  assign period_o = period_q;
  assign idx_o    = idx_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: doc/ks_note_seq.md
KS_NOTE_SEQ -- requirements
Module: ks_note_seq

Interface
REQ-001 Parameter DEPTH, default 8, number of note-table entries (power of two).
REQ-002 Parameter DATA_WIDTH, default 8, width of the period, duration and tempo fields.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 tick_i  input  1  one-clk strobe per string sample step (sequencer time base).
REQ-006 wr_en_i  input  1  note-table write strobe.
REQ-007 wr_addr_i  input  log2(DEPTH)  table entry written.
REQ-008 wr_period_i  input  DATA_WIDTH  period field of written entry.
REQ-009 wr_dur_i  input  DATA_WIDTH  duration field of written entry, in tempo units.
REQ-010 len_i  input  log2(DEPTH)+1  number of notes to play.
REQ-011 tempo_i  input  DATA_WIDTH  ticks per duration unit.
REQ-012 start_i, stop_i, loop_i  input  1 each  start playback, abort playback, repeat sequence.
REQ-013 pluck_o  output  1  pluck request to the string.
REQ-014 period_o  output  DATA_WIDTH  period of the current note to the string.
REQ-015 idx_o  output  log2(DEPTH)  index of the current note.
REQ-016 busy_o  output  1  high in LOAD and PLAY.
REQ-017 done_o  output  1  one-clk pulse at sequence end.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD and PLAY; busy_o SHALL be 0 only in IDLE.
REQ-019 In IDLE, start_i SHALL set idx to 0, sample len_i, tempo_i and loop_i into internal registers, and move to LOAD.
REQ-020 A sampled len of 0 SHALL be treated as 1, and a len above DEPTH SHALL be treated as DEPTH.
REQ-021 LOAD SHALL last exactly one clk and SHALL:
- copy table[idx].period into period_o;
- load dur_cnt with max(dur,1) and unit_cnt with max(tempo,1);
- clear pluck_cnt;
- then enter PLAY.
REQ-022 In PLAY, each tick_i SHALL decrement unit_cnt.
- When unit_cnt reaches 0, it SHALL reload max(tempo,1) and decrement dur_cnt.
- A note therefore SHALL last exactly max(dur,1)*max(tempo,1) ticks.
REQ-023 pluck_o SHALL be high from PLAY entry until 2 tick_i have been seen in that note, or until the note ends, whichever is first.
REQ-024 When dur_cnt reaches 0 and idx is below len-1, the block SHALL increment idx and enter LOAD on the next clk.
REQ-025 When dur_cnt reaches 0 and idx equals len-1, end-of-sequence handling SHALL follow REQ-035/REQ-036.
REQ-026 start_i SHALL be ignored while busy_o is high.
REQ-027 stop_i SHALL force IDLE on the next clk from any state, clearing pluck_o.
- stop_i SHALL take priority over start_i and over end-of-note handling.
- It SHALL produce no done_o pulse.
REQ-028 Table writes SHALL be accepted in every state and SHALL take effect at the next LOAD of that entry.
- When a write and a LOAD hit the same entry in the same clk, LOAD SHALL use the old value.
REQ-029 period_o and idx_o SHALL hold their last values in IDLE.
REQ-030 Arithmetic:
- all counters SHALL be unsigned DATA_WIDTH bits;
- no counter SHALL wrap below 0;
- idx SHALL wrap modulo DEPTH.

Reset
REQ-031 While rst_n is low at a clk edge, the block SHALL reset the FSM to IDLE.
REQ-032 Reset SHALL clear all table entries, counters, idx_o, period_o, pluck_o, busy_o and done_o to 0.
REQ-033 A reset in LOAD or PLAY SHALL abort playback without a done_o pulse, and pluck_o SHALL be 0 on the following cycle.

Configuration
REQ-034 Macro KS_SEQ_LOOP_EN SHALL select loop support.
REQ-035 With KS_SEQ_LOOP_EN defined and sampled loop=1, the last note SHALL be followed by LOAD with idx=0.
- Playback SHALL continue until stop_i.
- done_o SHALL never pulse.
REQ-036 Without KS_SEQ_LOOP_EN, loop_i SHALL be ignored.
- The last note SHALL always be followed by IDLE with a one-clk done_o pulse.

Verification
REQ-037 Write entry 0 {period 20, dur 2}, tempo 3, len 1, start -> period_o=20 one clk after LOAD, pluck_o high for 2 ticks, done_o after 6 ticks, busy_o low.
REQ-038 Entries 0..2 with dur 1, tempo 1, len 3 -> idx_o steps 0,1,2, each note 1 tick with pluck_o high for 1 tick, then a single done_o.
REQ-039 Entry with dur 0, tempo 0 -> note lasts 1 tick; len_i=0 -> one note played.
REQ-040 stop_i asserted together with start_i, and stop_i asserted mid-PLAY -> IDLE next clk, pluck_o 0, no done_o.
REQ-041 With KS_SEQ_LOOP_EN, loop=1, len 2 -> idx_o sequence 0,1,0,1 with done_o never asserted; without the macro -> done_o after the second note.
REQ-042 rst_n low mid-PLAY, then start without table writes -> period_o=0, idx_o=0, note lasts 1 tick.
